// File: rtl/serial_frame_tx_if.sv
// Load handshake and serial line bundle for serial_frame_tx.
// The slave modport is the transmitter side; master is the word source and line observer.
interface serial_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sdo;
  logic             busy;
  logic             done;

  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  sdo,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output sdo,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB-first, stop bit, DIV clocks per bit.
// Optional macro SFT_NEGEDGE_LAUNCH_EN retimes sdo through a falling-edge flop.
module serial_frame_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input logic             clk,
  input logic             rst_n,
  serial_frame_tx_if.slave bus
);

  localparam int DW = (DIV   > 1) ? $clog2(DIV)   : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_p0, state_nx;
  logic [DW-1:0]    div_p0, div_nx;
  logic [BW-1:0]    bit_p0, bit_nx;
  logic [WIDTH-1:0] shift_p0, shift_nx;
  logic             sdo_p0, sdo_nx;
  logic             done_p0, done_nx;
  logic             bit_end;

  // Line level for a given state: low only for the start bit, data follows the shifter LSB.
  function automatic logic line_level(input state_t s, input logic lsb);
    case (s)
      START:   line_level = 1'b0;
      DATA:    line_level = lsb;
      default: line_level = 1'b1;
    endcase
  endfunction

  assign bit_end = (div_p0 == DW'(DIV - 1));

  always_comb begin
    state_nx = state_p0;
    div_nx   = div_p0;
    bit_nx   = bit_p0;
    shift_nx = shift_p0;
    done_nx  = 1'b0;
    case (state_p0)
      IDLE: begin
        if (bus.load_valid) begin
          shift_nx = bus.din;
          state_nx = START;
          div_nx   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          div_nx   = '0;
          bit_nx   = '0;
        end else begin
          div_nx = div_p0 + DW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          div_nx   = '0;
          shift_nx = shift_p0 >> 1;
          if (bit_p0 == BW'(WIDTH - 1)) begin
            state_nx = STOP;
          end else begin
            bit_nx = bit_p0 + BW'(1);
          end
        end else begin
          div_nx = div_p0 + DW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          div_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          div_nx = div_p0 + DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // Registering the next-state level makes sdo fall on the accept edge itself.
    sdo_nx = line_level(state_nx, shift_nx[0]);
  end

  // Stage p0: rising-edge frame state and launched line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      div_p0   <= '0;
      bit_p0   <= '0;
      shift_p0 <= '0;
      sdo_p0   <= 1'b1;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      div_p0   <= div_nx;
      bit_p0   <= bit_nx;
      shift_p0 <= shift_nx;
      sdo_p0   <= sdo_nx;
      done_p0  <= done_nx;
    end
  end

  assign bus.load_ready = (state_p0 == IDLE);
  assign bus.busy       = (state_p0 != IDLE);
  assign bus.done       = done_p0;

`ifdef SFT_NEGEDGE_LAUNCH_EN
  logic sdo_p1;

  // Stage p1: falling-edge retime centres each bit on the receiver's rising-edge sample
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo_p1 <= 1'b1;
    end else begin
      sdo_p1 <= sdo_p0;
    end
  end

  assign bus.sdo = sdo_p1;
`else
  assign bus.sdo = sdo_p0;
`endif

endmodule
